// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU background fetch path: the fetch FSM
// state encoding and the fixed VRAM address constants.
package ppu_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CPU_REQ,
        CPU_WAIT,
        NT_REQ,
        NT_WAIT,
        AT_REQ,
        AT_WAIT,
        PL_REQ,
        PL_WAIT,
        PH_REQ,
        PH_WAIT,
        TILE_OUT
    } fetch_state_t;

    localparam logic [15:0] ATTR_BASE    = 16'h23C0;
    localparam logic [15:0] NT_SEL_MASK  = 16'h0C00;
    localparam logic [15:0] PLANE_HI_OFS = 16'h0008;
    localparam int          TILE_W       = 8;

endpackage

// File: rtl/bg_fetch_addr_gen.sv
// Combinational address generation for one background tile: attribute
// address and palette shift from the nametable pointer, and the two
// pattern-plane addresses from the fetched nametable byte.
module bg_fetch_addr_gen
    import ppu_pkg::*;
(
    input  logic [15:0] nt_ptr,
    input  logic [2:0]  fine_y,
    input  logic [7:0]  nt_byte,
    input  logic        table_sel,
    output logic [15:0] at_addr,
    output logic [15:0] pl_addr,
    output logic [15:0] ph_addr,
    output logic [2:0]  pal_shift
);

    // Attribute byte covers a 4x4 tile block; the 2x2 quadrant picks the bit pair.
    always_comb begin
        at_addr   = ATTR_BASE
                  | (nt_ptr & NT_SEL_MASK)
                  | ((nt_ptr >> 4) & 16'h0038)
                  | ((nt_ptr >> 2) & 16'h0007);
        pl_addr   = {3'b000, table_sel, nt_byte, 1'b0, fine_y};
        ph_addr   = pl_addr | PLANE_HI_OFS;
        pal_shift = {nt_ptr[6], nt_ptr[1], 1'b0};
    end

endmodule

// File: rtl/bg_fetch_scheduler.sv
// Background tile fetch scheduler: walks one scanline of tiles through
// NT/AT/PL/PH reads on the shared VRAM port, fits CPU PPUDATA accesses
// in between lines, and hands finished tiles to the shifter stage.
module bg_fetch_scheduler
    import ppu_pkg::*;
#(
    parameter int TILES_PER_LINE = 33,
    parameter int TILE_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_start,
    input  logic [8:0]  line_row,
    input  logic        render_en,
    input  logic        bg_table_sel,
    output logic [8:0]  xlat_row,
    output logic [8:0]  xlat_col,
    input  logic [15:0] xlat_nt_ptr,
    input  logic [2:0]  xlat_fine_y,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        tile_valid,
    input  logic        tile_ready,
    output logic [7:0]  tile_pat_lo,
    output logic [7:0]  tile_pat_hi,
    output logic [1:0]  tile_pal,
    output logic        line_busy,
    output logic        line_done
);

    localparam int IDX_W = $clog2(TILES_PER_LINE + 1);

    fetch_state_t     state, state_nxt;
    logic             start_pending;
    logic             start_take;
    logic             last_tile;
    logic [IDX_W-1:0] tile_idx;
    logic [15:0]      p_lat;
    logic [2:0]       fy_lat;
    logic [7:0]       nt_byte;
    logic             cpu_is_wr;
    logic [15:0]      at_addr, pl_addr, ph_addr;
    logic [2:0]       pal_shift;
    logic [7:0]       at_shifted;

    bg_fetch_addr_gen u_addr_gen (
        .nt_ptr    (p_lat),
        .fine_y    (fy_lat),
        .nt_byte   (nt_byte),
        .table_sel (bg_table_sel),
        .at_addr   (at_addr),
        .pl_addr   (pl_addr),
        .ph_addr   (ph_addr),
        .pal_shift (pal_shift)
    );

    assign xlat_col = 9'(tile_idx) * 9'(TILE_W);

    // A start is taken straight from the pulse when idle, so it beats a coincident CPU request.
    always_comb begin
        start_take = start_pending | (line_start & render_en);
        last_tile  = (tile_idx == IDX_W'(TILES_PER_LINE - 1));
        at_shifted = mem_rdata >> pal_shift;
        line_busy  = !(state inside {IDLE, CPU_REQ, CPU_WAIT});
    end

    // Next-state and port/handshake outputs; only *_REQ states drive the memory port.
    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 8'h00;
        cpu_ack    = 1'b0;
        cpu_rdata  = 8'h00;
        tile_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start_take)   state_nxt = NT_REQ;
                else if (cpu_req) state_nxt = CPU_REQ;
            end
            CPU_REQ: begin
                mem_req   = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                if (mem_gnt) state_nxt = CPU_WAIT;
            end
            CPU_WAIT: begin
                cpu_ack   = 1'b1;
                cpu_rdata = cpu_is_wr ? 8'h00 : mem_rdata;
                state_nxt = IDLE;
            end
            NT_REQ: begin
                mem_req  = 1'b1;
                mem_addr = xlat_nt_ptr;
                if (mem_gnt) state_nxt = NT_WAIT;
            end
            NT_WAIT: state_nxt = AT_REQ;
            AT_REQ: begin
                mem_req  = 1'b1;
                mem_addr = at_addr;
                if (mem_gnt) state_nxt = AT_WAIT;
            end
            AT_WAIT: state_nxt = PL_REQ;
            PL_REQ: begin
                mem_req  = 1'b1;
                mem_addr = pl_addr;
                if (mem_gnt) state_nxt = PL_WAIT;
            end
            PL_WAIT: state_nxt = PH_REQ;
            PH_REQ: begin
                mem_req  = 1'b1;
                mem_addr = ph_addr;
                if (mem_gnt) state_nxt = PH_WAIT;
            end
            PH_WAIT: state_nxt = TILE_OUT;
            TILE_OUT: begin
                tile_valid = 1'b1;
                if (tile_ready) state_nxt = last_tile ? IDLE : NT_REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: FSM, pending start, tile counter, latched row and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            start_pending <= 1'b0;
            tile_idx      <= '0;
            xlat_row      <= 9'd0;
            line_done     <= 1'b0;
        end else begin
            state     <= state_nxt;
            line_done <= 1'b0;
            if (state == IDLE) begin
                if (start_take) begin
                    start_pending <= 1'b0;
                    tile_idx      <= '0;
                    xlat_row      <= line_row;
                end
            end else if (line_start && render_en && !line_busy) begin
                start_pending <= 1'b1;
            end
            if (state == TILE_OUT && tile_ready) begin
                if (last_tile) begin
                    tile_idx  <= '0;
                    line_done <= 1'b1;
                end else begin
                    tile_idx <= tile_idx + 1'b1;
                end
            end
        end
    end

    // Tile outputs load in the WAIT states and stay frozen through TILE_OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            tile_pat_lo <= 8'h00;
            tile_pat_hi <= 8'h00;
            tile_pal    <= 2'b00;
        end else begin
            if (state == AT_WAIT) tile_pal    <= at_shifted[1:0];
            if (state == PL_WAIT) tile_pat_lo <= mem_rdata;
            if (state == PH_WAIT) tile_pat_hi <= mem_rdata;
        end
    end

    // Translator result is sampled when the nametable read is granted; NT byte and CPU direction are captured alongside.
    always_ff @(posedge clk) begin
        if (state == NT_REQ && mem_gnt) begin
            p_lat  <= xlat_nt_ptr;
            fy_lat <= xlat_fine_y;
        end
        if (state == NT_WAIT) nt_byte <= mem_rdata;
        if (state == CPU_REQ && mem_gnt) cpu_is_wr <= cpu_we;
    end

endmodule

// File: tb/tb_bg_fetch_scheduler.sv
// Directed bench for bg_fetch_scheduler: a vector table of single-tile
// fetches plus hand-written full-line, backpressure, arbitration and
// reset sequences against a small VRAM and translator model.
module tb_bg_fetch_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_start;
    logic [8:0]  line_row;
    logic        render_en;
    logic        bg_table_sel;
    logic [8:0]  xlat_row;
    logic [8:0]  xlat_col;
    logic [15:0] xlat_nt_ptr;
    logic [2:0]  xlat_fine_y;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_gnt;
    logic [7:0]  mem_rdata = 8'h00;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        tile_valid;
    logic        tile_ready;
    logic [7:0]  tile_pat_lo;
    logic [7:0]  tile_pat_hi;
    logic [1:0]  tile_pal;
    logic        line_busy;
    logic        line_done;

    always #5 clk = ~clk;

    bg_fetch_scheduler #(.TILES_PER_LINE(33), .TILE_W(8)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .line_row(line_row),
        .render_en(render_en), .bg_table_sel(bg_table_sel),
        .xlat_row(xlat_row), .xlat_col(xlat_col),
        .xlat_nt_ptr(xlat_nt_ptr), .xlat_fine_y(xlat_fine_y),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .tile_valid(tile_valid), .tile_ready(tile_ready),
        .tile_pat_lo(tile_pat_lo), .tile_pat_hi(tile_pat_hi), .tile_pal(tile_pal),
        .line_busy(line_busy), .line_done(line_done)
    );

    // Translator model: fixed pointer and fine-Y per test.
    logic [15:0] tb_p  = 16'h2000;
    logic [2:0]  tb_fy = 3'd0;
    assign xlat_nt_ptr = tb_p;
    assign xlat_fine_y = tb_fy;

    // VRAM contents per test, selected by address class.
    logic [7:0] v_nt = 8'h00, v_at = 8'h00, v_pl = 8'h00, v_ph = 8'h00;
    logic [7:0] next_rd = 8'h00;

    function automatic logic [7:0] mem_model(input logic [15:0] a);
        if (a >= 16'h3F00)      return 8'h5A;
        else if (a == tb_p)     return v_nt;
        else if (a >= 16'h2000) return v_at;
        else if (a[3])          return v_ph;
        else                    return v_pl;
    endfunction

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { logic [15:0] addr; logic we; logic [7:0] wdata; int cyc; } acc_t;
    typedef struct { logic [7:0] lo; logic [7:0] hi; logic [1:0] pal; logic [8:0] col; int cyc; } tile_t;
    acc_t  acc_q[$];
    tile_t tile_q[$];
    int    done_cnt = 0;
    int    done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) mem_rdata <= next_rd;

    // Monitor away from the active edge: granted accesses, accepted tiles, done pulses.
    always @(negedge clk) begin
        if (mem_req && mem_gnt) begin
            acc_q.push_back(acc_t'{mem_addr, mem_we, mem_wdata, cyc});
            next_rd <= mem_we ? 8'h00 : mem_model(mem_addr);
        end else begin
            next_rd <= 8'h00;
        end
        if (tile_valid && tile_ready)
            tile_q.push_back(tile_t'{tile_pat_lo, tile_pat_hi, tile_pal, xlat_col, cyc});
        if (line_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    function automatic acc_t acc_at(input int idx);
        acc_t r = acc_t'{16'hDEAD, 1'b1, 8'hEE, -1};
        if (idx >= 0 && idx < acc_q.size()) r = acc_q[idx];
        return r;
    endfunction

    function automatic tile_t tile_at(input int idx);
        tile_t r = tile_t'{8'hEE, 8'hEE, 2'b00, 9'h1FF, -1};
        if (idx >= 0 && idx < tile_q.size()) r = tile_q[idx];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_out();
        return |{mem_req, mem_we, mem_addr, mem_wdata, cpu_ack, cpu_rdata, tile_valid,
                 tile_pat_lo, tile_pat_hi, tile_pal, line_busy, line_done, xlat_row, xlat_col};
    endfunction

    task automatic do_reset();
        rst = 1'b1; line_start = 1'b0; cpu_req = 1'b0; tile_ready = 1'b0; mem_gnt = 1'b1;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] p; logic [2:0] fy; logic sel; logic [8:0] row;
        logic [7:0] nt; logic [7:0] at; logic [7:0] pl; logic [7:0] ph;
        logic [15:0] e_at; logic [15:0] e_pl; logic [15:0] e_ph; logic [1:0] e_pal;
    } vec_t;
    vec_t vt[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, a0, t0, d0, n, stall, ack_c;
        logic [7:0] h_lo, h_hi;
        logic [1:0] h_pal;
        tile_t tt;

        vt[0] = '{16'h2000, 3'd0, 1'b1, 9'd0,   8'h24, 8'hE4, 8'h81, 8'h7E, 16'h23C0, 16'h1240, 16'h1248, 2'd0};
        vt[1] = '{16'h2042, 3'd0, 1'b0, 9'd17,  8'h24, 8'hE4, 8'h3C, 8'hC3, 16'h23C0, 16'h0240, 16'h0248, 2'd3};
        vt[2] = '{16'h2002, 3'd5, 1'b0, 9'd100, 8'hFF, 8'hE4, 8'h01, 8'h80, 16'h23C0, 16'h0FF5, 16'h0FFD, 2'd1};
        vt[3] = '{16'h2C7F, 3'd7, 1'b1, 9'd239, 8'h00, 8'h9B, 8'hAA, 8'h55, 16'h2FC7, 16'h1007, 16'h100F, 2'd2};
        vt[4] = '{16'h27BD, 3'd3, 1'b0, 9'd255, 8'hA5, 8'h63, 8'hF0, 8'h0F, 16'h27FF, 16'h0A53, 16'h0A5B, 2'd3};

        rst = 1'b1; line_start = 1'b0; line_row = 9'd0; render_en = 1'b0; bg_table_sel = 1'b0;
        mem_gnt = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
        tile_ready = 1'b0;
        step(); step();
        chk("reset_outs", any_out(), 1'b0);
        rst = 1'b0;

        // Single-tile vectors: addresses, latency, tile data and palette.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            tb_p = vt[i].p; tb_fy = vt[i].fy; bg_table_sel = vt[i].sel; line_row = vt[i].row;
            v_nt = vt[i].nt; v_at = vt[i].at; v_pl = vt[i].pl; v_ph = vt[i].ph;
            a0 = acc_q.size();
            render_en = 1'b1; line_start = 1'b1; c0 = cyc;
            step();
            line_start = 1'b0;
            n = 0;
            while (!tile_valid && n < 20) begin step(); n++; end
            chk($sformatf("v%0d_valid", i), tile_valid, 1'b1);
            chk($sformatf("v%0d_latency", i), cyc - c0, 9);
            chk($sformatf("v%0d_nreq", i), acc_q.size() - a0, 4);
            chk($sformatf("v%0d_nt_addr", i), acc_at(a0).addr, vt[i].p);
            chk($sformatf("v%0d_at_addr", i), acc_at(a0 + 1).addr, vt[i].e_at);
            chk($sformatf("v%0d_pl_addr", i), acc_at(a0 + 2).addr, vt[i].e_pl);
            chk($sformatf("v%0d_ph_addr", i), acc_at(a0 + 3).addr, vt[i].e_ph);
            chk($sformatf("v%0d_we", i),
                acc_at(a0).we | acc_at(a0 + 1).we | acc_at(a0 + 2).we | acc_at(a0 + 3).we, 1'b0);
            chk($sformatf("v%0d_pat_lo", i), tile_pat_lo, vt[i].pl);
            chk($sformatf("v%0d_pat_hi", i), tile_pat_hi, vt[i].ph);
            chk($sformatf("v%0d_pal", i), tile_pal, vt[i].e_pal);
            chk($sformatf("v%0d_row", i), xlat_row, vt[i].row);
            chk($sformatf("v%0d_col", i), xlat_col, 9'd0);
            chk($sformatf("v%0d_busy", i), line_busy, 1'b1);
        end

        // Full line, tile_ready high; a second start while busy is ignored, render_en drops mid-line.
        do_reset();
        tb_p = 16'h2000; tb_fy = 3'd0; bg_table_sel = 1'b1;
        v_nt = 8'h24; v_at = 8'hE4; v_pl = 8'h81; v_ph = 8'h7E;
        a0 = acc_q.size(); t0 = tile_q.size(); d0 = done_cnt;
        tile_ready = 1'b1; render_en = 1'b1; line_row = 9'd40; line_start = 1'b1; c0 = cyc;
        step();
        line_start = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 400) begin
            line_start = (n == 50);
            if (n == 60) render_en = 1'b0;
            step(); n++;
        end
        line_start = 1'b0;
        chk("full_done_seen", done_cnt - d0, 1);
        chk("full_tiles", tile_q.size() - t0, 33);
        for (int k = 0; k < 33; k++)
            chk($sformatf("full_col%0d", k), tile_at(t0 + k).col, k * 8);
        tt = tile_at(t0 + 32);
        chk("full_last_accept", tt.cyc - c0, 297);
        chk("full_done_lat", done_cyc - tt.cyc, 1);
        chk("full_last_lo", tt.lo, 8'h81);
        repeat (20) step();
        chk("full_reqs", acc_q.size() - a0, 132);
        chk("full_done_once", done_cnt - d0, 1);
        chk("full_idle_busy", line_busy, 1'b0);

        // Backpressure: tile 3 held for 5 cycles.
        do_reset();
        v_pl = 8'h5C; v_ph = 8'hC5;
        a0 = acc_q.size(); t0 = tile_q.size(); d0 = done_cnt;
        render_en = 1'b1; tile_ready = 1'b1; line_start = 1'b1; c0 = cyc;
        step();
        line_start = 1'b0;
        stall = 0; n = 0; h_lo = 8'h00; h_hi = 8'h00; h_pal = 2'b00;
        while (done_cnt == d0 && n < 450) begin
            if (tile_valid && (tile_q.size() - t0) == 3 && stall < 5) begin
                tile_ready = 1'b0;
                if (stall == 0) begin
                    h_lo = tile_pat_lo; h_hi = tile_pat_hi; h_pal = tile_pal;
                end else begin
                    chk($sformatf("bp_hold%0d", stall), {tile_valid, tile_pat_lo, tile_pat_hi, tile_pal},
                        {1'b1, h_lo, h_hi, h_pal});
                end
                chk($sformatf("bp_no_req%0d", stall), mem_req, 1'b0);
                stall++;
            end else begin
                tile_ready = 1'b1;
            end
            step(); n++;
        end
        chk("bp_stalls", stall, 5);
        chk("bp_tile3_accept", tile_at(t0 + 3).cyc - c0, 41);
        chk("bp_tile3_data", {tile_at(t0 + 3).lo, tile_at(t0 + 3).hi}, 16'h5CC5);
        chk("bp_last_accept", tile_at(t0 + 32).cyc - c0, 302);
        chk("bp_reqs", acc_q.size() - a0, 132);

        // Arbitration: CPU write coincident with start waits for the whole line.
        do_reset();
        v_pl = 8'h81; v_ph = 8'h7E;
        a0 = acc_q.size(); d0 = done_cnt;
        tile_ready = 1'b1; render_en = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3F00; cpu_wdata = 8'h0F;
        line_start = 1'b1; c0 = cyc;
        step();
        line_start = 1'b0;
        n = 0;
        while (!cpu_ack && n < 500) begin step(); n++; end
        chk("arbA_ack_seen", cpu_ack, 1'b1);
        ack_c = cyc;
        chk("arbA_ack_rdata", cpu_rdata, 8'h00);
        cpu_req = 1'b0;
        chk("arbA_first_addr", acc_at(a0).addr, 16'h2000);
        chk("arbA_first_cyc", acc_at(a0).cyc - c0, 1);
        chk("arbA_done_before", done_cnt - d0, 1);
        chk("arbA_ack_after_done", ack_c - done_cyc, 2);
        chk("arbA_wr_access", {acc_at(acc_q.size() - 1).addr, acc_at(acc_q.size() - 1).we,
                               acc_at(acc_q.size() - 1).wdata}, {16'h3F00, 1'b1, 8'h0F});
        step();
        chk("arbA_ack_pulse", {cpu_ack, mem_req}, 2'b00);

        // Arbitration: start arrives while a CPU read is in flight (grant withheld).
        do_reset();
        mem_gnt = 1'b0; tb_p = 16'h2400;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3F10; cpu_wdata = 8'h00;
        step();
        chk("arbB_cpu_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'h3F10});
        line_start = 1'b1; render_en = 1'b1;
        step();
        line_start = 1'b0;
        chk("arbB_held", {mem_req, mem_addr, line_busy}, {1'b1, 16'h3F10, 1'b0});
        mem_gnt = 1'b1;
        step();
        chk("arbB_ack", {cpu_ack, cpu_rdata}, {1'b1, 8'h5A});
        cpu_req = 1'b0;
        step();
        chk("arbB_idle_gap", mem_req, 1'b0);
        step();
        chk("arbB_nt_req", {mem_req, mem_addr, line_busy}, {1'b1, 16'h2400, 1'b1});

        // Reset mid-line aborts silently.
        do_reset();
        tb_p = 16'h2000;
        tile_ready = 1'b1; render_en = 1'b1; t0 = tile_q.size(); line_start = 1'b1;
        step();
        line_start = 1'b0;
        n = 0;
        while ((tile_q.size() - t0) < 10 && n < 200) begin step(); n++; end
        chk("rst_reach_tile10", tile_q.size() - t0, 10);
        rst = 1'b1;
        step();
        chk("rst_mid_outs", any_out(), 1'b0);
        rst = 1'b0;
        d0 = done_cnt; t0 = tile_q.size(); a0 = acc_q.size();
        repeat (350) step();
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_no_tiles", tile_q.size() - t0, 0);
        chk("rst_no_reqs", acc_q.size() - a0, 0);

        // line_start with render_en low is ignored.
        do_reset();
        a0 = acc_q.size();
        render_en = 1'b0; line_start = 1'b1;
        step();
        line_start = 1'b0;
        repeat (20) step();
        chk("noren_reqs", acc_q.size() - a0, 0);
        chk("noren_busy", line_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
